alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised, buffered successor to the single-cycle combinational ALU.
- Accepts operations from NCH independent issuers (RS, LSB address generation, ...), arbitrating round-robin with one grant per cycle.
- Computes integer, branch, jump and address results, and queues them in a QDEPTH-entry result FIFO that drains to the CDB under a valid/ready handshake.
- Supports ROB flush and the global rdy stall.

Parameters:
- XLEN, 32, datapath width.
- ROB_W, 4, ROB entry tag width.
- NCH, 2, number of issue channels (channel 0 = RS, 1 = LSB).
- QDEPTH, 4, result FIFO depth (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  global enable; low = full stall.
- flush  in  1  ROB mispredict clear.
- in_valid  in  NCH  per-channel request.
- in_ready  out  NCH  per-channel grant (one-hot or zero).
- in_opcode  in  NCH*6  opcode per channel (defines.v encoding).
- in_lhs  in  NCH*XLEN  rs1 value.
- in_rhs  in  NCH*XLEN  rs2 value, or immediate for I-type.
- in_imm  in  NCH*XLEN  sign-extended offset.
- in_pc  in  NCH*XLEN  instruction pc.
- in_rob  in  NCH*ROB_W  destination ROB tag.
- cdb_valid  out  1  head entry present.
- cdb_ready  in  1  CDB accepts head.
- cdb_rob  out  ROB_W  tag of head.
- cdb_result  out  XLEN  result of head.
- cdb_jump  out  1  head redirects control flow (taken branch / jump).
- cdb_target  out  XLEN  redirect target of head.

Behaviour:
- Reset (rst high at posedge): FIFO empty, count=0, rr pointer=0. Outputs: cdb_valid=0, in_ready=0; cdb_rob/result/jump/target=0.
- pop = cdb_valid & cdb_ready & rdy & ~flush.
- space = (count<QDEPTH) | pop.
- Grant:
  - Channel i is granted when rdy & ~flush & space & in_valid[i], and i is the first valid channel at or after rr pointer, modulo NCH.
  - in_ready is combinational and at most one-hot.
  - Transfer occurs on in_valid[i] & in_ready[i].
  - After a grant to i, rr pointer = (i+1) mod NCH; otherwise it holds.
- Execute: the granted operands go through alu_core combinationally and the result is written into the FIFO tail at the same edge. Accept-to-cdb_valid latency is 1 cycle when the FIFO was empty.
- Result rules (lhs, rhs, imm, pc of the granted op):
  - ADD/ADDI lhs+rhs. SUB lhs-rhs. AND/OR/XOR and their I-forms are bitwise.
  - SLL/SRL/SRA and their I-forms use shamt=rhs[4:0]; SRA is arithmetic.
  - SLT/SLTI signed compare; SLTU/SLTIU unsigned compare; result is 0 or 1.
  - Branches (BEQ..BGEU): result = condition (0/1), jump = condition, target = pc+imm.
  - JAL: result = pc+4, jump=1, target = pc+imm.
  - JALR: result = pc+4, jump=1, target = (lhs+imm) & ~1.
  - LUI: result = imm. AUIPC: result = pc+imm.
  - L_OP/S_OP: result = lhs+imm (effective address).
  - Default: result, jump and target = 0.
  - For every non-branch, non-jump op: jump=0, target=0.
  - All arithmetic wraps modulo 2^XLEN.
- FIFO:
  - Circular buffer with head/tail pointers wrapping at QDEPTH.
  - Simultaneous push and pop at count==QDEPTH is legal; count stays QDEPTH.
  - Simultaneous push and pop at count==0 cannot occur, because cdb_valid=0.
  - cdb_* outputs come from head registers; they are not combinational from inputs.
- Flush high at an edge: FIFO emptied (count=0, pointers reset), nothing accepted or popped. rr pointer retained. cdb_valid=0 from the next cycle.
- rdy low: no grant, no pop, all state held. cdb_valid is forced 0 while rdy is low.
- rst has priority over flush; flush has priority over rdy.

Decomposition:
- Opcode constants stay in the shared defines.v.
- Add to defines.v: ALU_RES_W and a packed result-entry layout {jump, target, result, rob}.
- Sub-module alu_core: purely combinational; opcode, lhs, rhs, imm, pc -> result, jump, target.
- The arbiter and FIFO stay inline.

Test Plan:
- Reset then single op: ch0 ADD lhs=5 rhs=7 rob=3, cdb_ready=1 -> next cycle cdb_valid=1, rob=3, result=12, jump=0.
- Arbitration: ch0 and ch1 both valid continuously -> grants alternate 0,1,0,1. SRA lhs=0x80000000 rhs=4 -> 0xF8000000. L_OP lhs=0x100 imm=-4 -> 0xFC.
- Branch/jump: BNE lhs=1 rhs=2 pc=0x40 imm=0x10 -> result=1, jump=1, target=0x50. JALR lhs=0x1001 imm=2 pc=0x20 -> result=0x24, target=0x1002.
- Backpressure: cdb_ready=0 with QDEPTH=4 -> in_ready drops after 4 accepts. Raise cdb_ready with ch0 still valid -> push and pop in the same cycle, count stays 4, results drain in FIFO order.
- Flush: 3 entries queued, flush=1 for one cycle -> cdb_valid=0 next cycle, in_ready=0 during the flush cycle, and no queued tag reappears.
- rdy stall: rdy=0 for 3 cycles with 2 queued entries -> cdb_valid=0 and no grants. After rdy returns to 1 -> the same 2 entries are output in order.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared opcode encoding and result-entry layout for the buffered ALU execution unit.
package alu_exec_unit_pkg;

  localparam int unsigned OPC_W     = 6;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned ROB_W_DEF = 4;
  localparam int unsigned ALU_RES_W = 1 + 2 * XLEN_DEF + ROB_W_DEF;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,
    OP_SUB   = 6'd2,
    OP_AND   = 6'd3,
    OP_OR    = 6'd4,
    OP_XOR   = 6'd5,
    OP_SLL   = 6'd6,
    OP_SRL   = 6'd7,
    OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,
    OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_ANDI  = 6'd12,
    OP_ORI   = 6'd13,
    OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15,
    OP_SRLI  = 6'd16,
    OP_SRAI  = 6'd17,
    OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_BEQ   = 6'd20,
    OP_BNE   = 6'd21,
    OP_BLT   = 6'd22,
    OP_BGE   = 6'd23,
    OP_BLTU  = 6'd24,
    OP_BGEU  = 6'd25,
    OP_JAL   = 6'd26,
    OP_JALR  = 6'd27,
    OP_LUI   = 6'd28,
    OP_AUIPC = 6'd29,
    OP_L_OP  = 6'd30,
    OP_S_OP  = 6'd31
  } opcode_e;

  // Result-entry layout at the default widths: {jump, target, result, rob}.
  typedef struct packed {
    logic                 jump;
    logic [XLEN_DEF-1:0]  target;
    logic [XLEN_DEF-1:0]  result;
    logic [ROB_W_DEF-1:0] rob;
  } res_entry_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-channel and CDB signal bundle for alu_exec_unit.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NCH   = 2
);
  import alu_exec_unit_pkg::*;

  logic [NCH-1:0]                 in_valid;
  logic [NCH-1:0]                 in_ready;
  logic [NCH-1:0][OPC_W-1:0]      in_opcode;
  logic [NCH-1:0][XLEN-1:0]       in_lhs;
  logic [NCH-1:0][XLEN-1:0]       in_rhs;
  logic [NCH-1:0][XLEN-1:0]       in_imm;
  logic [NCH-1:0][XLEN-1:0]       in_pc;
  logic [NCH-1:0][ROB_W-1:0]      in_rob;

  logic                           cdb_valid;
  logic                           cdb_ready;
  logic [ROB_W-1:0]               cdb_rob;
  logic [XLEN-1:0]                cdb_result;
  logic                           cdb_jump;
  logic [XLEN-1:0]                cdb_target;

  modport master (
    output in_valid, in_opcode, in_lhs, in_rhs, in_imm, in_pc, in_rob, cdb_ready,
    input  in_ready, cdb_valid, cdb_rob, cdb_result, cdb_jump, cdb_target
  );

  modport slave (
    input  in_valid, in_opcode, in_lhs, in_rhs, in_imm, in_pc, in_rob, cdb_ready,
    output in_ready, cdb_valid, cdb_rob, cdb_result, cdb_jump, cdb_target
  );

endinterface

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational ALU: integer, compare, branch, jump and address results for one op.
module alu_exec_unit_alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [XLEN-1:0]  lhs,
  input  logic [XLEN-1:0]  rhs,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  result,
  output logic             jump,
  output logic [XLEN-1:0]  target
);

  localparam int unsigned SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] pc_link;
  logic [XLEN-1:0] lhs_imm;
  logic            br_taken;

  assign shamt   = rhs[SH_W-1:0];
  assign pc_imm  = pc + imm;
  assign pc_link = pc + XLEN'(4);
  assign lhs_imm = lhs + imm;

  // Branch condition, only meaningful for branch opcodes
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BEQ:  br_taken = (lhs == rhs);
      OP_BNE:  br_taken = (lhs != rhs);
      OP_BLT:  br_taken = ($signed(lhs) <  $signed(rhs));
      OP_BGE:  br_taken = ($signed(lhs) >= $signed(rhs));
      OP_BLTU: br_taken = (lhs <  rhs);
      OP_BGEU: br_taken = (lhs >= rhs);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    result = '0;
    jump   = 1'b0;
    target = '0;
    case (opcode)
      OP_ADD,  OP_ADDI:  result = lhs + rhs;
      OP_SUB:            result = lhs - rhs;
      OP_AND,  OP_ANDI:  result = lhs & rhs;
      OP_OR,   OP_ORI:   result = lhs | rhs;
      OP_XOR,  OP_XORI:  result = lhs ^ rhs;
      OP_SLL,  OP_SLLI:  result = lhs << shamt;
      OP_SRL,  OP_SRLI:  result = lhs >> shamt;
      OP_SRA,  OP_SRAI:  result = XLEN'($signed(lhs) >>> shamt);
      OP_SLT,  OP_SLTI:  result = XLEN'($signed(lhs) < $signed(rhs));
      OP_SLTU, OP_SLTIU: result = XLEN'(lhs < rhs);
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        result = XLEN'(br_taken);
        jump   = br_taken;
        target = pc_imm;
      end
      OP_JAL: begin
        result = pc_link;
        jump   = 1'b1;
        target = pc_imm;
      end
      OP_JALR: begin
        result = pc_link;
        jump   = 1'b1;
        target = lhs_imm & {{(XLEN-1){1'b1}}, 1'b0};
      end
      OP_LUI:            result = imm;
      OP_AUIPC:          result = pc_imm;
      OP_L_OP, OP_S_OP:  result = lhs_imm;
      default: begin
        result = '0;
        jump   = 1'b0;
        target = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-channel ALU execution unit: round-robin issue arbiter, ALU core, and a
// result FIFO draining to the CDB with flush and global-stall support.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ROB_W  = ROB_W_DEF,
  parameter int unsigned NCH    = 2,
  parameter int unsigned QDEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           flush,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic             jump;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  result;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           fifo [QDEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_nxt;
  logic [IDX_W-1:0] grant_idx;
  logic [NCH-1:0]   grant;
  logic             found;
  int unsigned      scan;
  logic             accept_en;
  logic             space;
  logic             push;
  logic             pop;
  logic [XLEN-1:0]  core_result;
  logic [XLEN-1:0]  core_target;
  logic             core_jump;
  entry_t           wr_entry;

  // Head handshake: valid is masked while stalled; flush suppresses the pop
  assign bus.cdb_valid = (count != '0) & rdy;
  assign pop           = bus.cdb_valid & bus.cdb_ready & ~flush;
  assign space         = (count < CNT_W'(QDEPTH)) | pop;
  assign accept_en     = ~rst & rdy & ~flush & space;

  // Round-robin search: first valid channel at or after rr_ptr
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      scan = (32'(rr_ptr) + k) % NCH;
      if (!found && bus.in_valid[IDX_W'(scan)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(scan);
      end
    end
    if (found && accept_en) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign bus.in_ready = grant;
  assign push         = |grant;
  assign rr_nxt       = (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + IDX_W'(1);

  alu_exec_unit_alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .opcode (bus.in_opcode[grant_idx]),
    .lhs    (bus.in_lhs[grant_idx]),
    .rhs    (bus.in_rhs[grant_idx]),
    .imm    (bus.in_imm[grant_idx]),
    .pc     (bus.in_pc[grant_idx]),
    .result (core_result),
    .jump   (core_jump),
    .target (core_target)
  );

  always_comb begin
    wr_entry.jump   = core_jump;
    wr_entry.target = core_target;
    wr_entry.result = core_result;
    wr_entry.rob    = bus.in_rob[grant_idx];
  end

  // FIFO and arbiter state; flush empties the queue but keeps the rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        fifo[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= wr_entry;
        tail       <= tail + PTR_W'(1);
        rr_ptr     <= rr_nxt;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.cdb_rob    = fifo[head].rob;
  assign bus.cdb_result = fifo[head].result;
  assign bus.cdb_jump   = fifo[head].jump;
  assign bus.cdb_target = fifo[head].target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ROB_W  = 4;
  localparam int unsigned NCH    = 2;
  localparam int unsigned QDEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_exec_unit_if #(.XLEN(XLEN), .ROB_W(ROB_W), .NCH(NCH)) bus ();

  alu_exec_unit #(
    .XLEN   (XLEN),
    .ROB_W  (ROB_W),
    .NCH    (NCH),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [5:0] op, input logic [31:0] lhs,
                       input logic [31:0] rhs, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] rob);
    bus.in_opcode[ch] = op;
    bus.in_lhs[ch]    = lhs;
    bus.in_rhs[ch]    = rhs;
    bus.in_imm[ch]    = imm;
    bus.in_pc[ch]     = pc;
    bus.in_rob[ch]    = rob;
    bus.in_valid[ch]  = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic [3:0] rob, input logic [31:0] res);
    check_eq({tag, "_valid"}, bus.cdb_valid, 1'b1);
    check_eq({tag, "_rob"}, bus.cdb_rob, rob);
    check_eq({tag, "_result"}, bus.cdb_result, res);
  endtask

  // Single op on an empty FIFO with cdb_ready high: grant, 1-cycle result, then drain
  task automatic issue_one(input string tag, input int ch, input logic [5:0] op,
                           input logic [31:0] lhs, input logic [31:0] rhs,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic [3:0] rob, input logic [31:0] exp_res,
                           input logic exp_jump, input logic [31:0] exp_tgt);
    logic [1:0] exp_grant;
    exp_grant = 2'b01 << ch;
    bus.cdb_ready = 1'b1;
    bus.in_valid  = '0;
    drive(ch, op, lhs, rhs, imm, pc, rob);
    #1;
    check_eq({tag, "_grant"}, bus.in_ready, exp_grant);
    step();
    bus.in_valid = '0;
    check_head(tag, rob, exp_res);
    check_eq({tag, "_jump"}, bus.cdb_jump, exp_jump);
    check_eq({tag, "_target"}, bus.cdb_target, exp_tgt);
    step();
    check_eq({tag, "_drained"}, bus.cdb_valid, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    rdy           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = '0;
    bus.in_opcode = '0;
    bus.in_lhs    = '0;
    bus.in_rhs    = '0;
    bus.in_imm    = '0;
    bus.in_pc     = '0;
    bus.in_rob    = '0;
    bus.cdb_ready = 1'b0;

    // Reset state, including no grant while reset is held
    step();
    step();
    drive(0, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
    #1;
    check_eq("rst_in_ready", bus.in_ready, 2'b00);
    check_eq("rst_cdb_valid", bus.cdb_valid, 1'b0);
    check_eq("rst_cdb_rob", bus.cdb_rob, 4'd0);
    check_eq("rst_cdb_result", bus.cdb_result, 32'd0);
    check_eq("rst_cdb_jump", bus.cdb_jump, 1'b0);
    check_eq("rst_cdb_target", bus.cdb_target, 32'd0);
    step();
    rst = 1'b0;
    bus.in_valid = '0;

    // Basic op; leaves rr pointer at channel 1
    issue_one("add", 0, OP_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3, 32'd12, 1'b0, 32'd0);

    // Both channels valid: grants alternate starting from channel 1
    bus.cdb_ready = 1'b1;
    drive(0, OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd1);
    drive(1, OP_L_OP, 32'h0000_0100, 32'd0, 32'hFFFF_FFFC, 32'd0, 4'd2);
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("arb_grant", bus.in_ready, (c % 2 == 0) ? 2'b10 : 2'b01);
      if (c > 0) begin
        if ((c - 1) % 2 == 0) check_head("arb_lop", 4'd2, 32'h0000_00FC);
        else                  check_head("arb_sra", 4'd1, 32'hF800_0000);
      end
      step();
    end
    bus.in_valid = '0;
    #1;
    check_head("arb_last", 4'd1, 32'hF800_0000);
    step();
    check_eq("arb_drained", bus.cdb_valid, 1'b0);

    // Branch, jump and edge-case results
    issue_one("bne", 0, OP_BNE, 32'd1, 32'd2, 32'h10, 32'h40, 4'd5, 32'd1, 1'b1, 32'h50);
    issue_one("jalr", 1, OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h20, 4'd6, 32'h24, 1'b1, 32'h1002);
    issue_one("bltu", 0, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 32'h80, 4'd7,
              32'd0, 1'b0, 32'h70);
    issue_one("jal", 1, OP_JAL, 32'd0, 32'd0, 32'h20, 32'h100, 4'd8, 32'h104, 1'b1, 32'h120);
    issue_one("sub_wrap", 0, OP_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 4'd9, 32'hFFFF_FFFF, 1'b0, 32'd0);
    issue_one("slt", 1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd10, 32'd1, 1'b0, 32'd0);
    issue_one("sltu", 0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd11, 32'd0, 1'b0, 32'd0);
    issue_one("lui", 1, OP_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'd0, 4'd12, 32'hABCD_E000, 1'b0, 32'd0);
    issue_one("auipc", 0, OP_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd13, 32'h3000, 1'b0, 32'd0);
    issue_one("nop", 1, OP_NOP, 32'h55, 32'h66, 32'h77, 32'h88, 4'd14, 32'd0, 1'b0, 32'd0);

    // Backpressure: four accepts fill the FIFO, then push+pop at full
    bus.cdb_ready = 1'b0;
    bus.in_valid  = '0;
    for (int k = 0; k < 5; k++) begin
      drive(0, OP_ADDI, 32'(k), 32'd100, 32'd0, 32'd0, 4'(k));
      #1;
      check_eq("bp_ready", bus.in_ready, (k < 4) ? 2'b01 : 2'b00);
      step();
    end
    check_head("bp_head", 4'd0, 32'd100);
    bus.cdb_ready = 1'b1;
    #1;
    check_eq("bp_pushpop_ready", bus.in_ready, 2'b01);
    step();
    bus.in_valid = '0;
    for (int k = 1; k < 5; k++) begin
      #1;
      check_head("bp_drain", 4'(k), 32'(100 + k));
      step();
    end
    #1;
    check_eq("bp_empty", bus.cdb_valid, 1'b0);

    // Flush with three entries queued
    bus.cdb_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(0, OP_ADD, 32'(k), 32'd0, 32'd0, 32'd0, 4'(7 + k));
      step();
    end
    check_head("flush_pre", 4'd7, 32'd0);
    flush = 1'b1;
    drive(0, OP_ADD, 32'd9, 32'd9, 32'd0, 32'd0, 4'd10);
    #1;
    check_eq("flush_in_ready", bus.in_ready, 2'b00);
    step();
    flush         = 1'b0;
    bus.in_valid  = '0;
    bus.cdb_ready = 1'b1;
    #1;
    check_eq("flush_empty", bus.cdb_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("flush_stays_empty", bus.cdb_valid, 1'b0);
    end
    issue_one("post_flush", 1, OP_XORI, 32'hFF, 32'h0F, 32'd0, 32'd0, 4'd4, 32'hF0, 1'b0, 32'd0);

    // Global stall with two entries queued
    bus.cdb_ready = 1'b0;
    drive(0, OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'd11);
    step();
    drive(0, OP_OR, 32'hF000, 32'h000F, 32'd0, 32'd0, 4'd12);
    step();
    rdy = 1'b0;
    bus.cdb_ready = 1'b1;
    drive(0, OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd13);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_cdb_valid", bus.cdb_valid, 1'b0);
      check_eq("stall_in_ready", bus.in_ready, 2'b00);
      step();
    end
    rdy = 1'b1;
    bus.in_valid = '0;
    #1;
    check_head("stall_out0", 4'd11, 32'hFF00);
    step();
    #1;
    check_head("stall_out1", 4'd12, 32'hF00F);
    step();
    #1;
    check_eq("stall_empty", bus.cdb_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
